serializer: RTL and testbench
=============================

SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter: WIDTH, default 8, number of parallel bits per frame (at least 2).
REQ-002 Port: clk  input  1  single clock, all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: ser_en  input  1  shift enable; one bit is emitted per enabled cycle.
REQ-005 Port: load  input  1  parallel-load strobe; captures p_data and starts a frame.
REQ-006 Port: p_data  input  WIDTH  parallel data word.
REQ-007 Port: ser_data  output  1  registered serial data bit.
REQ-008 Port: ser_done  output  1  registered flag; high once the last bit of the frame is on ser_data.

Function
REQ-009 The block SHALL hold a WIDTH-bit shift register, a bit counter of clog2(WIDTH) bits, and an active flag.
REQ-010 Load edge (load=1, regardless of ser_en): shift register <= p_data; counter <= 0; active <= 1; ser_done <= 0; ser_data unchanged.
REQ-011 Shift edge (load=0, ser_en=1, active=1):
- ser_data <= next bit in transmit order (REQ-022).
- shift register advances one position.
- counter increments.
REQ-012 On the shift edge where counter = WIDTH-1 (last bit): ser_done <= 1 and active <= 0, in the same edge that drives the last bit onto ser_data.
REQ-013 A frame SHALL take exactly WIDTH shift edges after the load edge; first bit valid on ser_data one cycle after the first shift edge is sampled, with no idle cycle between bits while ser_en stays 1.
REQ-014 Pause: ser_en=0 with load=0 mid-frame SHALL hold the shift register, counter, ser_data and ser_done; shifting resumes with the next enabled cycle.
REQ-015 Idle: ser_en=1 with active=0 (frame complete, or no frame loaded) SHALL hold all state; ser_data keeps the last emitted bit; ser_done stays 1 until the next load edge.
REQ-016 Load mid-frame SHALL abort the current frame and restart with the new p_data (load has priority over shift).
REQ-017 p_data SHALL be sampled only on load edges; changes at other times have no effect.

Reset
REQ-018 rst=0 SHALL immediately, independent of clk:
- clear the shift register, counter and active flag.
- drive ser_data=0 and ser_done=0.
REQ-019 Reset asserted mid-frame SHALL discard the frame; after release the block is idle until the next load edge.
REQ-020 Release of rst SHALL take effect at the next rising clk edge; no output changes on the release itself.

Configuration
REQ-021 Macro SER_MSB_FIRST_EN selects the transmit order.
REQ-022 Transmit order:
- Macro not defined (default): LSB first, p_data[0] first and p_data[WIDTH-1] last.
- Macro defined: MSB first, p_data[WIDTH-1] first and p_data[0] last.
- All timing, ser_done and reset behaviour are identical in both builds.

Verification
REQ-023 Reset: rst=0 for 60 time units mid-clock -> ser_data=0, ser_done=0 immediately; both stay 0 for 2 idle cycles with ser_en=load=0 after release.
REQ-024 Basic frame (default build, WIDTH=8): load=1, ser_en=1, p_data=8'b10011011 for one cycle, then load=0, ser_en=1 -> ser_data over the next 8 cycles = 1,1,0,1,1,0,0,1; ser_done=0 for bits 1-7 and 1 with bit 8; then ser_done stays 1 and ser_data holds 1 for 2 more cycles.
REQ-025 MSB-first build: same stimulus as REQ-024 -> ser_data sequence 1,0,0,1,1,0,1,1, with ser_done timing unchanged.
REQ-026 Pause: same stimulus as REQ-024, with ser_en=0 for 3 cycles after bit 4 -> ser_data holds bit 4 and ser_done=0 during the pause; the remaining bits 1,0,0,1 follow; total 11 cycles to ser_done.
REQ-027 Reload: load 8'hA5 and shift 3 bits, then load 8'h3C -> ser_done stays 0; the 8 bits of 8'h3C follow in transmit order, with no leftover bits from 8'hA5.
REQ-028 Reset mid-frame: assert rst=0 after bit 5 of a frame -> outputs clear immediately; with ser_en=1 and no load after release, ser_data=0 and ser_done=0 hold.

Source files
------------

// File: rtl/serializer.sv
// serializer: parallel-to-serial converter with load/shift/pause control.
//
// Loads a WIDTH-bit word on a load edge, then emits one bit per enabled
// cycle on ser_data. ser_done rises on the same edge that drives the last bit,
// and stays high until the next load edge.
//
// Build option: define SER_MSB_FIRST_EN to transmit MSB first. The default
// build transmits LSB first. Timing is identical in both builds.
//
// Ports:
//   clk      - clock, rising edge active
//   rst      - asynchronous active-low reset
//   ser_en   - shift enable, one bit per enabled cycle
//   load     - parallel load strobe; has priority over shifting
//   p_data   - parallel data word, sampled only on load edges
//   ser_data - registered serial data bit
//   ser_done - registered flag, high once the last bit is on ser_data
module serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_en,
  input  logic             load,
  input  logic [WIDTH-1:0] p_data,
  output logic             ser_data,
  output logic             ser_done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // SHIFT is the "active" flag: a frame is in progress.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             data_nxt;
  logic             done_nxt;

  logic             tx_bit;
  logic [WIDTH-1:0] sreg_shifted;

  // Transmit order: the outgoing bit and the register after one shift.
`ifdef SER_MSB_FIRST_EN
  assign tx_bit       = sreg[WIDTH-1];
  assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
`else
  assign tx_bit       = sreg[0];
  assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      ser_data <= 1'b0;
      ser_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      cnt      <= cnt_nxt;
      ser_data <= data_nxt;
      ser_done <= done_nxt;
    end
  end

  // Next-state logic: load beats shift; everything holds otherwise.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    data_nxt  = ser_data;
    done_nxt  = ser_done;

    if (load) begin
      sreg_nxt  = p_data;
      cnt_nxt   = '0;
      state_nxt = SHIFT;
      done_nxt  = 1'b0;
    end else if (ser_en && (state == SHIFT)) begin
      data_nxt = tx_bit;
      sreg_nxt = sreg_shifted;
      cnt_nxt  = cnt + CNT_W'(1);
      // Last bit goes out on this edge: flag completion in the same cycle.
      if (cnt == CNT_LAST) begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed self-checking bench for serializer (WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serializer;

  logic       clk;
  logic       rst;
  logic       ser_en;
  logic       load;
  logic [7:0] p_data;
  logic       ser_data;
  logic       ser_done;

  int total;
  int bad;

  serializer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ser_en   (ser_en),
    .load     (load),
    .p_data   (p_data),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected i-th transmitted bit of word w.
  function automatic logic exp_bit(input logic [7:0] w, input int i);
`ifdef SER_MSB_FIRST_EN
    return w[7 - i];
`else
    return w[i];
`endif
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] w;
    logic       last;
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    ser_en = 1'b0;
    load   = 1'b0;
    p_data = 8'h00;

    // Reset asserted mid-clock for 60 time units.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_async_data", ser_data, 1'b0);
    check("rst_async_done", ser_done, 1'b0);
    #59 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_idle_data", ser_data, 1'b0);
      check("rst_idle_done", ser_done, 1'b0);
    end

    // Enabled but no frame loaded: nothing moves.
    ser_en = 1'b1;
    @(negedge clk);
    check("noframe_data", ser_data, 1'b0);
    check("noframe_done", ser_done, 1'b0);

    // Basic frame; p_data scrambled after the load edge must not matter.
    w = 8'b1001_1011;
    load = 1'b1; ser_en = 1'b1; p_data = w;
    @(negedge clk);
    check("basic_load_done", ser_done, 1'b0);
    load = 1'b0; p_data = 8'h64;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("basic_bit", ser_data, exp_bit(w, i));
      check("basic_done", ser_done, (i == 7) ? 1'b1 : 1'b0);
      p_data = 8'(~p_data);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("basic_hold_data", ser_data, exp_bit(w, 7));
      check("basic_hold_done", ser_done, 1'b1);
    end

    // Pause for 3 cycles after bit 4.
    load = 1'b1; p_data = w;
    @(negedge clk);
    check("pause_load_done", ser_done, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pause_pre_bit", ser_data, exp_bit(w, i));
      check("pause_pre_done", ser_done, 1'b0);
    end
    ser_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pause_hold_data", ser_data, exp_bit(w, 3));
      check("pause_hold_done", ser_done, 1'b0);
    end
    ser_en = 1'b1;
    for (int i = 4; i < 8; i++) begin
      @(negedge clk);
      check("pause_post_bit", ser_data, exp_bit(w, i));
      check("pause_post_done", ser_done, (i == 7) ? 1'b1 : 1'b0);
    end

    // Reload mid-frame: A5 for 3 bits, then 3C in full.
    w = 8'hA5;
    load = 1'b1; p_data = w;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reload_a5_bit", ser_data, exp_bit(w, i));
    end
    last = exp_bit(w, 2);
    w = 8'h3C;
    load = 1'b1; p_data = w;
    @(negedge clk);
    check("reload_load_data", ser_data, last);
    check("reload_load_done", ser_done, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("reload_3c_bit", ser_data, exp_bit(w, i));
      check("reload_3c_done", ser_done, (i == 7) ? 1'b1 : 1'b0);
    end

    // Reset after bit 5 of a frame whose bit 5 is 1 in both orders.
    w = 8'b1001_1011;
    load = 1'b1; p_data = w;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_pre_bit", ser_data, exp_bit(w, i));
    end
    #2 rst = 1'b0;
    #1;
    check("midrst_async_data", ser_data, 1'b0);
    check("midrst_async_done", ser_done, 1'b0);
    #20 rst = 1'b1;
    #1;
    check("midrst_release_data", ser_data, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_idle_data", ser_data, 1'b0);
      check("midrst_idle_done", ser_done, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
